// File: rtl/command_handler_pkg.sv
// ============================================================================
// Module  : command_handler_pkg
// Brief   : Shared state codes, control characters and helpers for the
//           terminal command handler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package command_handler_pkg;

    localparam logic [2:0] ST_NORMAL = 3'd0;
    localparam logic [2:0] ST_ESC    = 3'd1;
    localparam logic [2:0] ST_Y_ROW  = 3'd2;
    localparam logic [2:0] ST_Y_COL  = 3'd3;
    localparam logic [2:0] ST_CLEAR  = 3'd4;

    localparam logic [7:0] CH_ESC = 8'h1B;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_BS  = 8'h08;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    localparam logic [7:0] ESC_UP        = 8'h41;  // 'A'
    localparam logic [7:0] ESC_DOWN      = 8'h42;  // 'B'
    localparam logic [7:0] ESC_RIGHT     = 8'h43;  // 'C'
    localparam logic [7:0] ESC_LEFT      = 8'h44;  // 'D'
    localparam logic [7:0] ESC_HOME      = 8'h48;  // 'H'
    localparam logic [7:0] ESC_CLR_SCR   = 8'h4A;  // 'J'
    localparam logic [7:0] ESC_CLR_LINE  = 8'h4B;  // 'K'
    localparam logic [7:0] ESC_DIRECT    = 8'h59;  // 'Y'

    localparam logic [7:0] Y_OFFSET = 8'h20;

    // Direct-cursor coordinate: subtract the offset, floor at 0, cap at limit.
    function automatic logic [7:0] offset_clamp(input logic [7:0] code,
                                                input logic [7:0] limit);
        logic [7:0] diff;
        logic [7:0] result;
        diff = code - Y_OFFSET;
        if (code < Y_OFFSET)
            result = 8'd0;
        else if (diff > limit)
            result = limit;
        else
            result = diff;
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/command_handler_cursor_clamp.sv
// ============================================================================
// Module  : cursor_clamp
// Brief   : Saturating increment / decrement of a SIZE-bit cursor index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cursor_clamp #(
    parameter int SIZE = 6
) (
    input  logic [SIZE-1:0] i_value,
    output logic [SIZE-1:0] o_inc,
    output logic [SIZE-1:0] o_dec
);

    assign o_inc = (i_value == {SIZE{1'b1}}) ? i_value : i_value + SIZE'(1);
    assign o_dec = (i_value == {SIZE{1'b0}}) ? i_value : i_value - SIZE'(1);

endmodule

`default_nettype wire

// File: rtl/command_handler.sv
// ============================================================================
// Module  : command_handler
// Brief   : Decodes the host byte stream (printables, controls, VT52 escapes)
//           into character-buffer writes and cursor updates.
//           Define COMMAND_HANDLER_AUTOWRAP_EN to wrap at the last column.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module command_handler
    import command_handler_pkg::*;
#(
    parameter int         COLS_BITS  = 6,
    parameter int         ROWS_BITS  = 4,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    output logic [7:0]                    new_char,
    output logic [COLS_BITS+ROWS_BITS-1:0] new_char_address,
    output logic                          new_char_wen,
    output logic [COLS_BITS-1:0]          new_cursor_x,
    output logic [ROWS_BITS-1:0]          new_cursor_y,
    output logic                          write_cursor_pos
);

    localparam int         ADDR_BITS = COLS_BITS + ROWS_BITS;
    localparam logic [7:0] COL_LIMIT = 8'((1 << COLS_BITS) - 1);
    localparam logic [7:0] ROW_LIMIT = 8'((1 << ROWS_BITS) - 1);

    logic [2:0]           state_q,     state_d;
    logic                 ready_q,     ready_d;
    logic [7:0]           char_q,      char_d;
    logic [ADDR_BITS-1:0] addr_q,      addr_d;
    logic                 wen_q,       wen_d;
    logic [COLS_BITS-1:0] x_q,         x_d;
    logic [ROWS_BITS-1:0] y_q,         y_d;
    logic                 wcp_q,       wcp_d;
    logic [ROWS_BITS-1:0] row_lat_q,   row_lat_d;
    logic [ADDR_BITS-1:0] clr_addr_q,  clr_addr_d;
    logic [ADDR_BITS-1:0] clr_end_q,   clr_end_d;
    logic                 clr_last_q,  clr_last_d;

    logic [COLS_BITS-1:0] w_x_inc, w_x_dec;
    logic [ROWS_BITS-1:0] w_y_inc, w_y_dec;
    logic [ROWS_BITS-1:0] w_row_code;
    logic [COLS_BITS-1:0] w_col_code;
    logic [ADDR_BITS-1:0] w_cur_addr;
    logic                 w_accept;
    logic                 w_printable;

    cursor_clamp #(.SIZE(COLS_BITS)) u_clamp_x (
        .i_value (x_q),
        .o_inc   (w_x_inc),
        .o_dec   (w_x_dec)
    );

    cursor_clamp #(.SIZE(ROWS_BITS)) u_clamp_y (
        .i_value (y_q),
        .o_inc   (w_y_inc),
        .o_dec   (w_y_dec)
    );

    assign w_row_code  = ROWS_BITS'(offset_clamp(data, ROW_LIMIT));
    assign w_col_code  = COLS_BITS'(offset_clamp(data, COL_LIMIT));
    assign w_cur_addr  = {y_q, x_q};
    assign w_accept    = valid & ready_q;
    assign w_printable = (data >= PRINT_MIN) && (data <= PRINT_MAX);

    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        addr_d     = addr_q;
        wen_d      = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        row_lat_d  = row_lat_q;
        clr_addr_d = clr_addr_q;
        clr_end_d  = clr_end_q;
        clr_last_d = clr_last_q;

        case (state_q)
            ST_NORMAL: begin
                if (w_accept) begin
                    if (w_printable) begin
                        wen_d  = 1'b1;
                        char_d = data;
                        addr_d = w_cur_addr;
`ifdef COMMAND_HANDLER_AUTOWRAP_EN
                        if (&x_q) begin
                            x_d = '0;
                            y_d = w_y_inc;
                        end else begin
                            x_d = w_x_inc;
                        end
`else
                        x_d = w_x_inc;
`endif
                    end else begin
                        case (data)
                            CH_CR:   x_d     = '0;
                            CH_LF:   y_d     = w_y_inc;
                            CH_BS:   x_d     = w_x_dec;
                            CH_ESC:  state_d = ST_ESC;
                            default: ;
                        endcase
                    end
                end
            end

            ST_ESC: begin
                if (w_accept) begin
                    state_d = ST_NORMAL;
                    case (data)
                        ESC_UP:    y_d = w_y_dec;
                        ESC_DOWN:  y_d = w_y_inc;
                        ESC_RIGHT: x_d = w_x_inc;
                        ESC_LEFT:  x_d = w_x_dec;
                        ESC_HOME: begin
                            x_d = '0;
                            y_d = '0;
                        end
                        ESC_CLR_SCR, ESC_CLR_LINE: begin
                            // First blank goes out with the command itself.
                            wen_d      = 1'b1;
                            char_d     = BLANK_CHAR;
                            addr_d     = w_cur_addr;
                            clr_addr_d = w_cur_addr + ADDR_BITS'(1);
                            clr_end_d  = (data == ESC_CLR_SCR) ? {ADDR_BITS{1'b1}}
                                                               : {y_q, {COLS_BITS{1'b1}}};
                            clr_last_d = (w_cur_addr == clr_end_d);
                            state_d    = ST_CLEAR;
                        end
                        ESC_DIRECT: state_d = ST_Y_ROW;
                        default: ;
                    endcase
                end
            end

            ST_Y_ROW: begin
                if (w_accept) begin
                    row_lat_d = w_row_code;
                    state_d   = ST_Y_COL;
                end
            end

            ST_Y_COL: begin
                if (w_accept) begin
                    y_d     = row_lat_q;
                    x_d     = w_col_code;
                    state_d = ST_NORMAL;
                end
            end

            ST_CLEAR: begin
                if (clr_last_q) begin
                    state_d = ST_NORMAL;
                end else begin
                    wen_d      = 1'b1;
                    char_d     = BLANK_CHAR;
                    addr_d     = clr_addr_q;
                    clr_addr_d = clr_addr_q + ADDR_BITS'(1);
                    clr_last_d = (clr_addr_q == clr_end_q);
                end
            end

            default: state_d = ST_NORMAL;
        endcase

        ready_d = (state_d != ST_CLEAR);
        wcp_d   = (x_d != x_q) || (y_d != y_q);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_NORMAL;
            ready_q    <= 1'b0;
            char_q     <= 8'd0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            wcp_q      <= 1'b0;
            row_lat_q  <= '0;
            clr_addr_q <= '0;
            clr_end_q  <= '0;
            clr_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            char_q     <= char_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            x_q        <= x_d;
            y_q        <= y_d;
            wcp_q      <= wcp_d;
            row_lat_q  <= row_lat_d;
            clr_addr_q <= clr_addr_d;
            clr_end_q  <= clr_end_d;
            clr_last_q <= clr_last_d;
        end
    end

    assign ready            = ready_q;
    assign new_char         = char_q;
    assign new_char_address = addr_q;
    assign new_char_wen     = wen_q;
    assign new_cursor_x     = x_q;
    assign new_cursor_y     = y_q;
    assign write_cursor_pos = wcp_q;

endmodule

`default_nettype wire

// File: tb/tb_command_handler.sv
// ============================================================================
// Module  : tb_command_handler
// Brief   : Self-checking bench for command_handler (reference model + random).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_command_handler;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  data = 8'd0;
    logic        valid = 1'b0;
    logic        ready;
    logic [7:0]  new_char;
    logic [9:0]  new_char_address;
    logic        new_char_wen;
    logic [5:0]  new_cursor_x;
    logic [3:0]  new_cursor_y;
    logic        write_cursor_pos;

    command_handler dut (
        .clk              (clk),
        .clr              (clr),
        .data             (data),
        .valid            (valid),
        .ready            (ready),
        .new_char         (new_char),
        .new_char_address (new_char_address),
        .new_char_wen     (new_char_wen),
        .new_cursor_x     (new_cursor_x),
        .new_cursor_y     (new_cursor_y),
        .write_cursor_pos (write_cursor_pos)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (terminal semantics) ----------------
    localparam int M_NORM = 0, M_ESC = 1, M_YROW = 2, M_YCOL = 3, M_CLR = 4;

    int   mx = 0, my = 0, mstate = M_NORM, mrow = 0;
    int   clrq[$];
    logic e_ready = 1'b0, e_wen = 1'b0, e_wcp = 1'b0;
    int   e_char = 0, e_addr = 0;
    bit   chk_en = 1'b0;

    function automatic int lim(input logic [7:0] d, input int top);
        int v;
        v = int'(d) - 32;
        if (v < 0) v = 0;
        if (v > top) v = top;
        return v;
    endfunction

    always @(posedge clk or posedge clr) begin : model
        int  px, py, s, e;
        bit  acc, clr_write;
        if (clr) begin
            mx = 0; my = 0; mstate = M_NORM; mrow = 0;
            clrq.delete();
            e_ready = 1'b0; e_wen = 1'b0; e_wcp = 1'b0;
            e_char = 0; e_addr = 0;
        end else begin
            px = mx; py = my;
            acc = valid && e_ready;
            e_wen = 1'b0;
            clr_write = 1'b0;
            case (mstate)
                M_NORM: if (acc) begin
                    if (data >= 8'h20 && data <= 8'h7E) begin
                        e_wen = 1'b1; e_char = int'(data); e_addr = my * 64 + mx;
                        if (mx < 63) mx = mx + 1;
                        else begin
`ifdef COMMAND_HANDLER_AUTOWRAP_EN
                            mx = 0;
                            my = (my < 15) ? my + 1 : 15;
`endif
                        end
                    end else if (data == 8'h0D) mx = 0;
                    else if (data == 8'h0A) my = (my < 15) ? my + 1 : 15;
                    else if (data == 8'h08) mx = (mx > 0) ? mx - 1 : 0;
                    else if (data == 8'h1B) mstate = M_ESC;
                end
                M_ESC: if (acc) begin
                    mstate = M_NORM;
                    case (data)
                        8'h41: my = (my > 0) ? my - 1 : 0;
                        8'h42: my = (my < 15) ? my + 1 : 15;
                        8'h43: mx = (mx < 63) ? mx + 1 : 63;
                        8'h44: mx = (mx > 0) ? mx - 1 : 0;
                        8'h48: begin mx = 0; my = 0; end
                        8'h4A, 8'h4B: begin
                            s = my * 64 + mx;
                            e = (data == 8'h4A) ? 1023 : my * 64 + 63;
                            for (int a = s; a <= e; a++) clrq.push_back(a);
                            e_wen = 1'b1; e_char = 32; e_addr = clrq.pop_front();
                            clr_write = 1'b1;
                            mstate = M_CLR;
                        end
                        8'h59: mstate = M_YROW;
                        default: ;
                    endcase
                end
                M_YROW: if (acc) begin
                    mrow = lim(data, 15);
                    mstate = M_YCOL;
                end
                M_YCOL: if (acc) begin
                    my = mrow;
                    mx = lim(data, 63);
                    mstate = M_NORM;
                end
                default: begin
                    if (clrq.size() > 0) begin
                        e_wen = 1'b1; e_char = 32; e_addr = clrq.pop_front();
                        clr_write = 1'b1;
                    end else begin
                        mstate = M_NORM;
                    end
                end
            endcase
            e_ready = !clr_write;
            e_wcp = (mx != px) || (my != py);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'd0, ready}, {31'd0, e_ready});
            chk("wen", {31'd0, new_char_wen}, {31'd0, e_wen});
            chk("wcp", {31'd0, write_cursor_pos}, {31'd0, e_wcp});
            chk("cur_x", {26'd0, new_cursor_x}, mx);
            chk("cur_y", {28'd0, new_cursor_y}, my);
            if (e_wen) begin
                chk("char", {24'd0, new_char}, e_char);
                chk("addr", {22'd0, new_char_address}, e_addr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        while (!e_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready_bound", {31'd0, e_ready}, 1);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic set_cursor(input int r, input int c);
        send(8'h1B); send(8'h59); send(8'(32 + r)); send(8'(32 + c));
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            0:  return 8'h0D;
            1:  return 8'h0A;
            2:  return 8'h08;
            3, 4, 5: return 8'h1B;
            6:  return 8'h41 + 8'($urandom_range(0, 3));
            7:  return 8'h48;
            8:  return ($urandom_range(0, 7) == 0) ? 8'h4A : 8'h4B;
            9:  return 8'h59;
            10: return 8'($urandom);
            default: return 8'($urandom_range(32, 126));
        endcase
    endfunction

    initial begin : main
        int lows, nw, first, last;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_wen", {31'd0, new_char_wen}, 0);
        chk("rst_char", {24'd0, new_char}, 0);
        chk("rst_addr", {22'd0, new_char_address}, 0);
        chk("rst_xy", {22'd0, new_cursor_y, new_cursor_x}, 0);
        clr = 1'b0;
        @(negedge clk);
        chk("ready_rise", {31'd0, ready}, 1);

        send(8'h48);
        chk("H_char", {24'd0, new_char}, 32'h48);
        chk("H_addr", {22'd0, new_char_address}, 0);
        chk("H_pulse", {31'd0, write_cursor_pos}, 1);
        send(8'h69);
        chk("i_char", {24'd0, new_char}, 32'h69);
        chk("i_addr", {22'd0, new_char_address}, 1);
        chk("i_x", {26'd0, new_cursor_x}, 2);

        set_cursor(5, 10);
        chk("Y_row", {28'd0, new_cursor_y}, 5);
        chk("Y_col", {26'd0, new_cursor_x}, 10);
        chk("Y_nowrite", {31'd0, new_char_wen}, 0);
        send(8'h1B); send(8'h59); send(8'h7F); send(8'h7F);
        chk("Ymax_row", {28'd0, new_cursor_y}, 15);
        chk("Ymax_col", {26'd0, new_cursor_x}, 63);

        set_cursor(3, 60);
        send(8'h1B); send(8'h4B);
        lows = 0; nw = 0; first = -1; last = -1;
        for (int i = 0; i < 8; i++) begin
            if (!ready) lows++;
            if (new_char_wen) begin
                nw++;
                if (first < 0) first = int'(new_char_address);
                last = int'(new_char_address);
            end
            @(negedge clk);
        end
        chk("K_ready_low", lows, 4);
        chk("K_writes", nw, 4);
        chk("K_first", first, 252);
        chk("K_last", last, 255);
        chk("K_cursor", {22'd0, new_cursor_y, new_cursor_x}, 3 * 64 + 60);

        send(8'h1B); send(8'h48);
        send(8'h1B); send(8'h4A);
        repeat (99) @(negedge clk);
        chk("J_write100_addr", {22'd0, new_char_address}, 99);
        #2 clr = 1'b1;
        #1;
        chk("clr_wen", {31'd0, new_char_wen}, 0);
        chk("clr_ready", {31'd0, ready}, 0);
        chk("clr_addr", {22'd0, new_char_address}, 0);
        @(negedge clk);
        clr = 1'b0;
        nw = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (new_char_wen) nw++;
        end
        chk("clr_no_writes", nw, 0);

        send(8'h1B);
        @(posedge clk);
        #2 clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        send(8'h42);
        chk("esc_abandon_char", {24'd0, new_char}, 32'h42);

        send(8'h1B); send(8'h48);
        send(8'h08);
        chk("BS_clamp_pulse", {31'd0, write_cursor_pos}, 0);
        send(8'h1B); send(8'h41);
        chk("A_clamp_y", {28'd0, new_cursor_y}, 0);
        set_cursor(15, 0);
        send(8'h0A);
        chk("LF_clamp_y", {28'd0, new_cursor_y}, 15);
        chk("LF_clamp_pulse", {31'd0, write_cursor_pos}, 0);

        send(8'h1B); send(8'h48);
        for (int i = 0; i < 64; i++) send(8'(8'h30 + i % 10));
        chk("p64_addr", {22'd0, new_char_address}, 63);
`ifdef COMMAND_HANDLER_AUTOWRAP_EN
        chk("p64_cursor", {22'd0, new_cursor_y, new_cursor_x}, 64);
`else
        chk("p64_cursor", {22'd0, new_cursor_y, new_cursor_x}, 63);
`endif

        for (int c = 0; c < 8000; c++) begin
            valid = 1'($urandom_range(0, 1));
            data  = pick();
            @(negedge clk);
        end
        valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
